// File: rtl/fcs_serializer_pkg.sv
// Shared types for the FCS serializer: FSM state encoding and
// the default generator width the remainder width derives from.
package fcs_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fcs_state_e;

    localparam int unsigned FCS_GEN_WIDTH = 17;

endpackage

// File: rtl/fcs_serializer.sv
// Serialises an FCS remainder onto LANES output bits per clock with
// ready/valid load, selectable bit order, optional inversion and abort.
module fcs_serializer
    import fcs_serializer_pkg::*;
#(
    parameter int unsigned REM_WIDTH = FCS_GEN_WIDTH - 1,
    parameter int unsigned LANES     = 1,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [REM_WIDTH-1:0] FCS_result,
    input  logic                 FCS_valid,
    output logic                 FCS_ready,
    input  logic                 Invert,
    input  logic                 Abort,
    output logic [LANES-1:0]     Ser_Data,
    output logic                 Valid_Out,
    output logic                 Last_Out,
    output logic                 Shift_done,
    output logic                 Busy
);

    localparam int unsigned BEATS = REM_WIDTH / LANES;
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((REM_WIDTH % LANES) != 0 || REM_WIDTH < 2) begin : g_bad_cfg
        $error("fcs_serializer: LANES must divide REM_WIDTH, REM_WIDTH >= 2");
    end

    fcs_state_e           state_q, state_d;
    logic [REM_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LANES-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;

    logic [REM_WIDTH-1:0] load_w;
    logic [REM_WIDTH-1:0] src_w;
    logic [REM_WIDTH-1:0] rest_w;
    logic [LANES-1:0]     head_w;

    // In IDLE the fresh word feeds the beat mux so beat 0 leaves on the load edge.
    assign load_w = Invert ? ~FCS_result : FCS_result;
    assign src_w  = (state_q == ST_IDLE) ? load_w : sreg_q;

    if (MSB_FIRST != 0) begin : g_msb
        assign head_w = src_w[REM_WIDTH-1 -: LANES];
        assign rest_w = src_w << LANES;
    end else begin : g_lsb
        assign head_w = src_w[LANES-1:0];
        assign rest_w = src_w >> LANES;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (FCS_valid) state_d = ST_SHIFT;
            ST_SHIFT: if (last_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (Abort) state_d = ST_IDLE;
    end

    // Everything defaults to zero so abort and DONE clear the datapath.
    always_comb begin
        sreg_d  = '0;
        cnt_d   = '0;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        if (!Abort) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (FCS_valid) begin
                        sreg_d  = rest_w;
                        data_d  = head_w;
                        valid_d = 1'b1;
                        last_d  = (BEATS == 1);
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (last_q) begin
                        done_d = 1'b1;
                    end else begin
                        sreg_d  = rest_w;
                        data_d  = head_w;
                        valid_d = 1'b1;
                        last_d  = (cnt_q == LAST_CNT);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign FCS_ready  = (state_q == ST_IDLE);
    assign Busy       = (state_q != ST_IDLE);
    assign Ser_Data   = data_q;
    assign Valid_Out  = valid_q;
    assign Last_Out   = last_q;
    assign Shift_done = done_q;

endmodule
